caliptra_sram_zbe: RTL and testbench

Parametrised single-port synchronous SRAM with per-byte write strobes, selectable read latency (1 or 2 cycles), a read-valid indication, and a hardware zeroization sequencer that clears every word on request. It is the next-generation local memory for Caliptra crypto and mailbox sub-blocks, where partial-word updates and guaranteed secret erasure are required.

---
 rtl/caliptra_sram_zbe_if.sv | 33 +++
 rtl/caliptra_sram_zbe.sv | 155 +++++++++++++++
 tb/tb_caliptra_sram_zbe.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/caliptra_sram_zbe_if.sv
`default_nettype none
// ============================================================================
// Module   : caliptra_sram_zbe_if
// Desc     : Host access and zeroization bus of the caliptra_sram_zbe memory.
// Revision : 1.0 - initial release
// ============================================================================
interface caliptra_sram_zbe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_BYTES  = (DATA_WIDTH + 7) / 8
);
    logic                  cs_i;
    logic                  we_i;
    logic [NUM_BYTES-1:0]  wstrb_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  rvalid_o;
    logic                  zeroize_req_i;
    logic                  zeroize_busy_o;
    logic                  zeroize_done_o;

    modport master (
        output cs_i, we_i, wstrb_i, addr_i, wdata_i, zeroize_req_i,
        input  rdata_o, rvalid_o, zeroize_busy_o, zeroize_done_o
    );

    modport slave (
        input  cs_i, we_i, wstrb_i, addr_i, wdata_i, zeroize_req_i,
        output rdata_o, rvalid_o, zeroize_busy_o, zeroize_done_o
    );
endinterface
`default_nettype wire

// File: rtl/caliptra_sram_zbe.sv
`default_nettype none
// ============================================================================
// Module   : caliptra_sram_zbe
// Desc     : Single-port SRAM with byte strobes, 1/2-cycle read latency and a
//            hardware zeroization sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module caliptra_sram_zbe #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RD_LATENCY = 1
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    caliptra_sram_zbe_if.slave bus
);

    localparam int                  NUM_BYTES = (DATA_WIDTH + 7) / 8;
    localparam logic [ADDR_WIDTH:0] C_DEPTH   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam bit                  C_LAT2    = (RD_LATENCY == 2);

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rd_latency
            $error("caliptra_sram_zbe: RD_LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] cnt_q,      cnt_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  rvalid_q,   rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;

    logic                  in_range;
    logic                  host_acc;
    logic                  rd_acc;
    logic                  flush;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_mask;
    logic [DATA_WIDTH-1:0] strb_mask;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    // Bit-level write mask; the top lane may be narrower than 8 bits.
    always_comb begin
        strb_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            strb_mask[i] = bus.wstrb_i[i / 8];
        end
    end

    assign in_range = ({1'b0, bus.addr_i} < C_DEPTH);
    assign rd_word  = in_range ? mem_q[bus.addr_i] : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush     = 1'b0;
        host_acc  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = bus.addr_i;
        mem_wdata = bus.wdata_i;
        mem_mask  = strb_mask;
        case (state_q)
            ST_IDLE: begin
                if (bus.zeroize_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    flush   = 1'b1;
                end else begin
                    host_acc = bus.cs_i;
                    mem_we   = bus.cs_i & bus.we_i & in_range;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                mem_mask  = '1;
                if (cnt_q == C_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        rd_acc     = host_acc & ~bus.we_i;
        s1_valid_d = rd_acc;
        s1_data_d  = rd_acc ? rd_word : s1_data_q;

        // Entry into CLEAR squashes whatever the read pipeline holds.
        out_valid  = C_LAT2 ? s1_valid_q : rd_acc;
        out_data   = C_LAT2 ? s1_data_q  : rd_word;
        rvalid_d   = out_valid & ~flush;
        rdata_d    = flush ? '0 : (out_valid ? out_data : rdata_q);

        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_addr] <= (mem_q[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
        end
    end

    assign bus.rdata_o        = rdata_q;
    assign bus.rvalid_o       = rvalid_q;
    assign bus.zeroize_busy_o = busy_q;
    assign bus.zeroize_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_caliptra_sram_zbe.sv
`default_nettype none
// ============================================================================
// Module   : tb_caliptra_sram_zbe
// Desc     : Latency-1 and latency-2 instances driven in lockstep against a
//            queue-based reference model of the memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_caliptra_sram_zbe;

    localparam int DEPTH = 48;
    localparam int DW    = 32;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0, we = 1'b0, zreq = 1'b0;
    logic [3:0]    wstrb = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;

    always #5 clk = ~clk;

    caliptra_sram_zbe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES(4)) bus1 ();
    caliptra_sram_zbe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES(4)) bus2 ();

    assign bus1.cs_i = cs;       assign bus2.cs_i = cs;
    assign bus1.we_i = we;       assign bus2.we_i = we;
    assign bus1.wstrb_i = wstrb; assign bus2.wstrb_i = wstrb;
    assign bus1.addr_i = addr;   assign bus2.addr_i = addr;
    assign bus1.wdata_i = wdata; assign bus2.wdata_i = wdata;
    assign bus1.zeroize_req_i = zreq;
    assign bus2.zeroize_req_i = zreq;

    caliptra_sram_zbe #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    caliptra_sram_zbe #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2)) u_dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    int          n_vec = 0, n_err = 0;
    int          edge_cnt = 0, busy_left = 0, clr_idx = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] hold1 = '0, hold2 = '0;
    rd_t         pend1[$], pend2[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Effect of the inputs present just before the coming rising edge.
    task automatic model_edge();
        logic [31:0] d;
        edge_cnt++;
        if (busy_left > 0) begin
            if (clr_idx < DEPTH) begin
                mem_m[clr_idx] = '0;
                clr_idx++;
            end
            busy_left--;
        end else if (zreq) begin
            busy_left = DEPTH + 1;
            clr_idx   = 0;
            pend1.delete();
            pend2.delete();
            hold1 = '0;
            hold2 = '0;
        end else if (cs && we) begin
            if (int'(addr) < DEPTH)
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) mem_m[addr][b*8 +: 8] = wdata[b*8 +: 8];
        end else if (cs) begin
            d = (int'(addr) < DEPTH) ? mem_m[addr] : 32'h0;
            pend1.push_back('{edge_cnt, d});
            pend2.push_back('{edge_cnt + 1, d});
        end
    endtask

    task automatic check_outputs();
        rd_t  r;
        logic v1, v2;
        v1 = 1'b0;
        v2 = 1'b0;
        if (pend1.size() > 0 && pend1[0].due == edge_cnt) begin
            r = pend1.pop_front(); hold1 = r.data; v1 = 1'b1;
        end
        if (pend2.size() > 0 && pend2[0].due == edge_cnt) begin
            r = pend2.pop_front(); hold2 = r.data; v2 = 1'b1;
        end
        chk("l1_rvalid", 32'(bus1.rvalid_o), 32'(v1));
        chk("l1_rdata",  bus1.rdata_o, hold1);
        chk("l1_busy",   32'(bus1.zeroize_busy_o), 32'(busy_left > 0));
        chk("l1_done",   32'(bus1.zeroize_done_o), 32'(busy_left == 1));
        chk("l2_rvalid", 32'(bus2.rvalid_o), 32'(v2));
        chk("l2_rdata",  bus2.rdata_o, hold2);
        chk("l2_busy",   32'(bus2.zeroize_busy_o), 32'(busy_left > 0));
        chk("l2_done",   32'(bus2.zeroize_done_o), 32'(busy_left == 1));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cs = 1'b0; we = 1'b0; zreq = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s);
        cs = 1'b1; we = 1'b1; addr = AW'(a); wdata = d; wstrb = s; zreq = 1'b0;
        tick();
        idle();
    endtask

    task automatic rd(input int a);
        cs = 1'b1; we = 1'b0; addr = AW'(a); zreq = 1'b0;
        tick();
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        busy_left = 0;
        clr_idx   = 0;
        pend1.delete();
        pend2.delete();
        hold1 = '0;
        hold2 = '0;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        edge_cnt++;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        idle();
        for (int g = 0; g < 200 && busy_left > 0; g++) tick();
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) rd(a);
        tick();
        tick();
    endtask

    initial begin
        int n, dn;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        tick();

        for (int a = 0; a < DEPTH; a++) wr(a, 32'hA5A5A5A5, 4'hF);

        // Byte-strobe merge
        wr(5, 32'hAABBCCDD, 4'hF);
        wr(5, 32'h11223344, 4'b0101);
        wr(6, 32'h0BADF00D, 4'h0);
        rd(5);
        chk("strobe_l1_valid", 32'(bus1.rvalid_o), 32'd1);
        chk("strobe_l1_data",  bus1.rdata_o, 32'hAA22CC44);
        tick();
        chk("strobe_l2_data",  bus2.rdata_o, 32'hAA22CC44);
        rd(6);
        tick();

        // Back-to-back streaming
        for (int i = 0; i < 4; i++) wr(i, 32'h10 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) begin
            cs = 1'b1; we = 1'b0; addr = AW'(i);
            tick();
            if (i > 0) chk("stream_l2", bus2.rdata_o, 32'h10 + 32'(i) - 32'd1);
        end
        idle();
        tick();
        chk("stream_l2_last", bus2.rdata_o, 32'h13);
        tick();

        // Out-of-range access
        wr(50, 32'h12345678, 4'hF);
        rd(50);
        chk("oor_valid", 32'(bus1.rvalid_o), 32'd1);
        chk("oor_data",  bus1.rdata_o, 32'h0);
        read_all();

        // Reset ten cycles into a clear
        for (int a = 0; a < DEPTH; a++) wr(a, 32'hA5A5A5A5, 4'hF);
        zreq = 1'b1;
        tick();
        zreq = 1'b0;
        repeat (10) tick();
        do_reset();
        rd(9);
        chk("rst_clear_w9", bus1.rdata_o, 32'h0);
        rd(10);
        chk("rst_clear_w10", bus1.rdata_o, 32'hA5A5A5A5);
        read_all();

        // Full clear with host writes attempted while busy
        zreq = 1'b1;
        tick();
        zreq = 1'b0;
        n  = 0;
        dn = 0;
        for (int g = 0; g < 100 && bus1.zeroize_busy_o; g++) begin
            n++;
            if (bus1.zeroize_done_o) dn++;
            cs = 1'b1; we = 1'b1; wstrb = 4'hF;
            addr = AW'($urandom_range(0, DEPTH - 1)); wdata = $urandom;
            tick();
        end
        idle();
        chk("busy_len", 32'(n), 32'd49);
        chk("done_pulses", 32'(dn), 32'd1);
        read_all();

        // Same-edge read and zeroize request
        wr(7, 32'hDEADBEEF, 4'hF);
        cs = 1'b1; we = 1'b0; addr = AW'(7); zreq = 1'b1;
        tick();
        chk("arb_no_rvalid", 32'(bus1.rvalid_o), 32'd0);
        wait_idle();

        // Latency-2 read squashed by the following zeroize
        wr(3, 32'hCAFEF00D, 4'hF);
        cs = 1'b1; we = 1'b0; addr = AW'(3);
        tick();
        cs = 1'b0; zreq = 1'b1;
        tick();
        chk("squash_l2_rvalid", 32'(bus2.rvalid_o), 32'd0);
        chk("squash_l2_rdata",  bus2.rdata_o, 32'h0);
        wait_idle();

        // Request held through DONE restarts a clear
        zreq = 1'b1;
        repeat (DEPTH + 3) tick();
        wait_idle();
        read_all();

        // Randomised traffic
        for (int a = 0; a < DEPTH; a++) wr(a, $urandom, 4'hF);
        for (int k = 0; k < 400; k++) begin
            cs    = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1) == 1;
            addr  = AW'($urandom_range(0, 55));
            wdata = $urandom;
            wstrb = 4'($urandom_range(0, 15));
            zreq  = ($urandom_range(0, 59) == 0);
            tick();
        end
        wait_idle();
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
